spike_serializer: RTL and testbench
===================================

SPIKE_SERIALIZER -- requirements
Module: spike_serializer

Interface
REQ-001: Parameter LEN, default 8, frame length in time steps (LEN >= 2).
REQ-002: Parameter IDLE_GAP, default 0, number of forced-silent cycles inserted after every frame.
REQ-003: Parameter CNT_W, default 16, width of the completed-frame counter.
REQ-004: clk  input  1  single clock; all state updates on the rising edge.
REQ-005: rst_n  input  1  reset, asynchronous and active-low.
REQ-006: in_valid  input  1  upstream spike frame (shifter output) is present.
REQ-007: in_frame  input  [0:LEN-1]  spike frame; index LEN-1 is t=0 and index 0 is t=LEN-1; multiple set bits are a union of spikes.
REQ-008: in_ready  output  1  block can accept a frame this cycle.
REQ-009: out_valid  output  1  spike_out and t_out carry a live time step.
REQ-010: spike_out  output  1  spike at the current time step.
REQ-011: t_out  output  $clog2(LEN)  time index of the current step.
REQ-012: frame_start  output  1  one-cycle pulse on the t_out=0 step of each frame.
REQ-013: frame_done  output  1  one-cycle pulse on the t_out=LEN-1 step of each frame.
REQ-014: frame_cnt  output  CNT_W  count of completed frames, modulo 2^CNT_W.

Function
REQ-015: The block SHALL hold one active frame register plus one pending register; in_ready = NOT pending_valid while rst_n is high.
REQ-016: A frame SHALL be accepted on a rising edge where in_valid and in_ready are both 1; in_frame is sampled on that edge only.
REQ-017: The state machine SHALL use states IDLE, RUN and GAP.
REQ-018: IDLE: an accept SHALL load the active register directly and enter RUN with t=0 on the next cycle, giving 1-cycle latency.
REQ-019: RUN: out_valid=1, spike_out=active[LEN-1-t], t_out=t; t SHALL increment by 1 each cycle.
REQ-020: RUN: an accept while the active frame is not in its last step SHALL fill the pending register, and in_ready SHALL go 0 on the next cycle.
REQ-021: RUN, last step (t=LEN-1): frame_done=1 and frame_cnt SHALL increment on that edge, wrapping from 2^CNT_W-1 to 0.
REQ-022: Last step with IDLE_GAP=0: if pending is valid, pending SHALL move to active with t=0 on the next cycle (no bubble) and pending SHALL clear.
REQ-023: Last step with IDLE_GAP=0 and pending empty: a simultaneous accept SHALL bypass pending straight into active; with no accept the block SHALL go to IDLE.
REQ-024: Last step with IDLE_GAP>0: the block SHALL enter GAP for exactly IDLE_GAP cycles; a simultaneous accept SHALL fill pending.
REQ-025: GAP: out_valid=0, spike_out=0, t_out=0; accepts SHALL fill pending.
REQ-026: GAP exit: go to RUN with t=0 if pending is valid (pending moves to active), otherwise go to IDLE.
REQ-027: IDLE and GAP: out_valid, spike_out, frame_start and frame_done SHALL be 0, and t_out SHALL be 0.
REQ-028: An all-zero frame SHALL still occupy LEN RUN cycles and SHALL count in frame_cnt.
REQ-029: All outputs except in_ready SHALL be registered.

Reset
REQ-030: On rst_n low, asynchronously: state=IDLE, t=0, pending_valid=0, active and pending registers cleared, frame_cnt=0.
REQ-031: On rst_n low, out_valid, spike_out, t_out, frame_start, frame_done and in_ready SHALL all be 0.
REQ-032: Reset mid-frame SHALL discard both the active and pending frames; after release in_ready=1 and state=IDLE.

Verification (LEN=8, IDLE_GAP=0 unless stated)
REQ-033: Accept 8'b0000_0010 at edge 0 -> out_valid cycles 1-8; spike_out=1 only when t_out=1 (cycle 2); frame_start cycle 1; frame_done cycle 8; frame_cnt=1; IDLE at cycle 9.
REQ-034: in_valid held with frames A=8'b0000_0001 then B=8'b1000_0000 -> B enters pending at edge 1; in_ready=0 cycles 2-8; out_valid high 16 consecutive cycles; spikes at A t=0 and B t=7; frame_cnt=2.
REQ-035: IDLE_GAP=2 with two back-to-back frames -> exactly 2 cycles of out_valid=0 between frame_done of the first frame and frame_start of the second.
REQ-036: Assert rst_n low at t_out=3 with pending full -> all outputs 0 immediately; after release in_ready=1, out_valid stays 0, and no stale spikes appear.
REQ-037: CNT_W=2, five frames of 8'h00 -> out_valid high 40 cycles, spike_out always 0, frame_cnt sequence 1,2,3,0,1.
REQ-038: Pending empty and in_valid=1 exactly on a frame_done cycle -> the new frame starts at t=0 on the next cycle through the bypass path with no gap cycle.

Source files
------------

// File: rtl/spike_serializer.sv
// Spike frame serializer: takes a LEN-step spike frame and replays it one
// time step per cycle. There is one active frame register and one pending
// register, and an optional run of forced-silent GAP cycles after each frame.
module spike_serializer #(
  parameter int unsigned LEN      = 8,
  parameter int unsigned IDLE_GAP = 0,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic [0:LEN-1]          in_frame,
  output logic                    in_ready,
  output logic                    out_valid,
  output logic                    spike_out,
  output logic [$clog2(LEN)-1:0]  t_out,
  output logic                    frame_start,
  output logic                    frame_done,
  output logic [CNT_W-1:0]        frame_cnt
);

  localparam int unsigned TW    = $clog2(LEN);
  localparam int unsigned GW    = (IDLE_GAP > 1) ? $clog2(IDLE_GAP) : 1;
  localparam logic [TW-1:0] TLast = TW'(LEN - 1);
  localparam logic [GW-1:0] GLast = GW'((IDLE_GAP > 0) ? IDLE_GAP - 1 : 0);

  typedef enum logic [1:0] {StIdle, StRun, StGap} state_e;

  state_e           state_q, state_d;
  logic [TW-1:0]    t_q, t_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic [0:LEN-1]   active_q, active_d;
  logic [0:LEN-1]   pend_q, pend_d;
  logic             pend_valid_q, pend_valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             accept;
  logic [TW-1:0]    idx;
  logic             out_valid_d, spike_d, start_d, done_d;
  logic [TW-1:0]    t_out_d;

  // Readiness is combinational so that a free pending slot can be used in
  // the same cycle; it is forced low while reset is asserted.
  assign in_ready  = rst_n & ~pend_valid_q;
  assign accept    = in_valid & in_ready;
  assign frame_cnt = cnt_q;

  // State, datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      t_q          <= '0;
      gap_q        <= '0;
      active_q     <= '0;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      cnt_q        <= '0;
      out_valid    <= 1'b0;
      spike_out    <= 1'b0;
      t_out        <= '0;
      frame_start  <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      state_q      <= state_d;
      t_q          <= t_d;
      gap_q        <= gap_d;
      active_q     <= active_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      cnt_q        <= cnt_d;
      out_valid    <= out_valid_d;
      spike_out    <= spike_d;
      t_out        <= t_out_d;
      frame_start  <= start_d;
      frame_done   <= done_d;
    end
  end

  // Next-state: frame sequencing, pending handoff and the completed-frame count.
  always_comb begin
    state_d      = state_q;
    t_d          = t_q;
    gap_d        = gap_q;
    active_d     = active_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    cnt_d        = cnt_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          active_d = in_frame;
          t_d      = '0;
          state_d  = StRun;
        end
      end
      StRun: begin
        if (t_q != TLast) begin
          t_d = t_q + TW'(1);
          if (accept) begin
            pend_d       = in_frame;
            pend_valid_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          t_d   = '0;
          if (IDLE_GAP == 0) begin
            // Back-to-back: pending first, else a same-cycle accept bypasses pending.
            if (pend_valid_q) begin
              active_d     = pend_q;
              pend_valid_d = 1'b0;
            end else if (accept) begin
              active_d = in_frame;
            end else begin
              state_d = StIdle;
            end
          end else begin
            state_d = StGap;
            gap_d   = '0;
            if (accept) begin
              pend_d       = in_frame;
              pend_valid_d = 1'b1;
            end
          end
        end
      end
      StGap: begin
        if (gap_q == GLast) begin
          t_d = '0;
          // An accept on the final gap cycle goes straight to active so it is not lost.
          if (pend_valid_q) begin
            active_d     = pend_q;
            pend_valid_d = 1'b0;
            state_d      = StRun;
          end else if (accept) begin
            active_d = in_frame;
            state_d  = StRun;
          end else begin
            state_d = StIdle;
          end
        end else begin
          gap_d = gap_q + GW'(1);
          if (accept) begin
            pend_d       = in_frame;
            pend_valid_d = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Output decode from the next state so every output leaves a flop.
  always_comb begin
    idx         = TLast - t_d;
    out_valid_d = (state_d == StRun);
    spike_d     = out_valid_d & active_d[idx];
    t_out_d     = out_valid_d ? t_d : '0;
    start_d     = out_valid_d && (t_d == '0);
    done_d      = out_valid_d && (t_d == TLast);
  end

endmodule

// File: tb/tb_spike_serializer.sv
// Bench for spike_serializer: two instances (back-to-back with a 16-bit count,
// and a 2-cycle gap with a 2-bit count) share stimulus. Each is compared every
// cycle with a schedule model: a frame accepted in cycle a starts at
// max(a+1, previous start + LEN + gap) and is pending in between.
module tb_spike_serializer;

  localparam int LEN  = 8;
  localparam int MAXF = 1024;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic [0:LEN-1] in_frame = '0;

  logic           rdy [2];
  logic           ov  [2];
  logic           sp  [2];
  logic           fs  [2];
  logic           fd  [2];
  logic [2:0]     tt  [2];
  logic [15:0]    cnt0;
  logic [1:0]     cnt1;

  int n_checks = 0;
  int n_bad    = 0;
  int cyc      = 0;

  int gap_of [2] = '{0, 2};
  int cmask  [2] = '{32'hFFFF, 3};
  int nf     [2];
  int acc_c  [2][MAXF];
  int st_c   [2][MAXF];
  int fr     [2][MAXF];

  spike_serializer #(.LEN(8), .IDLE_GAP(0), .CNT_W(16)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_frame(in_frame),
    .in_ready(rdy[0]), .out_valid(ov[0]), .spike_out(sp[0]), .t_out(tt[0]),
    .frame_start(fs[0]), .frame_done(fd[0]), .frame_cnt(cnt0)
  );

  spike_serializer #(.LEN(8), .IDLE_GAP(2), .CNT_W(2)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_frame(in_frame),
    .in_ready(rdy[1]), .out_valid(ov[1]), .spike_out(sp[1]), .t_out(tt[1]),
    .frame_start(fs[1]), .frame_done(fd[1]), .frame_cnt(cnt1)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] cnt_of(input int d);
    return (d == 0) ? 32'(cnt0) : 32'(cnt1);
  endfunction

  // Compare every output of both instances with the model, record accepts,
  // then advance to just after the next rising edge.
  task automatic step();
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      int ev, et, esp, ecnt, erdy, s;
      ev = 0; et = 0; esp = 0; ecnt = 0; erdy = 0;
      if (!rst_n) begin
        nf[d] = 0;
      end else begin
        erdy = 1;
        for (int k = 0; k < nf[d]; k++) begin
          if (cyc >= st_c[d][k] && cyc <= st_c[d][k] + LEN - 1) begin
            ev  = 1;
            et  = cyc - st_c[d][k];
            esp = (fr[d][k] >> et) & 1;
          end
          if (st_c[d][k] + LEN - 1 <= cyc - 1) ecnt++;
          if (acc_c[d][k] + 1 <= cyc && cyc <= st_c[d][k] - 1) erdy = 0;
        end
        ecnt = ecnt & cmask[d];
      end
      check_eq($sformatf("d%0d_out_valid", d), 32'(ov[d]), 32'(ev));
      check_eq($sformatf("d%0d_spike_out", d), 32'(sp[d]), 32'(esp));
      check_eq($sformatf("d%0d_t_out", d), 32'(tt[d]), 32'(et));
      check_eq($sformatf("d%0d_frame_start", d), 32'(fs[d]), 32'(ev && et == 0));
      check_eq($sformatf("d%0d_frame_done", d), 32'(fd[d]), 32'(ev && et == LEN - 1));
      check_eq($sformatf("d%0d_frame_cnt", d), cnt_of(d), 32'(ecnt));
      check_eq($sformatf("d%0d_in_ready", d), 32'(rdy[d]), 32'(erdy));
      if (rst_n && in_valid && erdy != 0 && nf[d] < MAXF) begin
        s = cyc + 1;
        if (nf[d] > 0 && st_c[d][nf[d]-1] + LEN + gap_of[d] > s)
          s = st_c[d][nf[d]-1] + LEN + gap_of[d];
        acc_c[d][nf[d]] = cyc;
        st_c[d][nf[d]]  = s;
        fr[d][nf[d]]    = int'(in_frame);
        nf[d]++;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic send(input logic [7:0] f);
    in_valid = 1'b1;
    in_frame = f;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    logic [7:0] f;
    int dens;
    nf[0] = 0;
    nf[1] = 0;

    // Reset state
    step();
    step();
    rst_n = 1'b1;
    idle(2);

    // Single frame with a spike at t=1
    send(8'b0000_0010);
    idle(14);

    // A then B back-to-back; B goes pending
    in_valid = 1'b1;
    in_frame = 8'b0000_0001;
    step();
    in_frame = 8'b1000_0000;
    step();
    idle(26);

    // New frame presented exactly on the frame_done cycle of the first
    send(8'b0101_0011);
    idle(7);
    send(8'b1100_0001);
    idle(22);

    // All-zero frames streamed; exercises the 2-bit counter wrap
    in_valid = 1'b1;
    in_frame = 8'h00;
    for (int i = 0; i < 40; i++) step();
    idle(30);

    // Reset mid-frame with pending full, at t_out=3 of the active frame
    in_valid = 1'b1;
    in_frame = 8'b1111_1111;
    step();
    in_frame = 8'b1010_1010;
    step();
    idle(2);
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      check_eq($sformatf("d%0d_rst_out_valid", d), 32'(ov[d]), 32'd0);
      check_eq($sformatf("d%0d_rst_spike", d), 32'(sp[d]), 32'd0);
      check_eq($sformatf("d%0d_rst_t_out", d), 32'(tt[d]), 32'd0);
      check_eq($sformatf("d%0d_rst_in_ready", d), 32'(rdy[d]), 32'd0);
      check_eq($sformatf("d%0d_rst_cnt", d), cnt_of(d), 32'd0);
    end
    step();
    step();
    rst_n = 1'b1;
    idle(20);

    // Randomized traffic with occasional resets
    dens = 50;
    for (int i = 0; i < 1500; i++) begin
      if (i % 100 == 0) dens = $urandom_range(5, 100);
      if ($urandom_range(0, 399) == 0) rst_n = 1'b0;
      f = 8'($urandom);
      in_frame = f;
      in_valid = ($urandom_range(0, 99) < dens);
      step();
      rst_n = 1'b1;
    end
    idle(30);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
